// File: rtl/image_loader.sv
`default_nettype none
// ============================================================================
// Module      : image_loader
// Description : Streams a header+pixel image into data memory through a byte
//               write port and holds the processor until the image is complete.
// Revision    : 1.0 - initial release
// ============================================================================
module image_loader #(
    parameter int unsigned           ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]     BASE_ADDR  = 32'h100,
    parameter int unsigned           MAX_PIXELS = 16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       pix_count
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HEADER = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_PIXELS = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_ERROR  = 3'd5;

    localparam logic [31:0] C_MAX_PIXELS = 32'(MAX_PIXELS);
    localparam logic [31:0] C_HDR_BYTES  = 32'd4;

    logic [2:0]        state_q, state_d;
    logic [31:0]       idx_q, idx_d;
    logic [15:0]       width_q, width_d;
    logic [15:0]       height_q, height_d;
    logic [31:0]       pix_count_q, pix_count_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              hold_q, hold_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_din_q, mem_din_d;

    logic              w_hs;
    logic              w_start_ok;
    logic [31:0]       w_product;
    logic              w_bad_hdr;
    logic [31:0]       w_offset;

    assign w_hs       = s_valid && s_ready;
    assign w_start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                  (state_q == ST_ERROR));
    assign w_product  = {16'd0, width_q} * {16'd0, height_q};
    assign w_bad_hdr  = (width_q == 16'd0) || (height_q == 16'd0) ||
                        (w_product > C_MAX_PIXELS);
    // Pixels sit directly after the 4-byte header in memory.
    assign w_offset   = (state_q == ST_PIXELS) ? (idx_q + C_HDR_BYTES) : idx_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_HEADER;
            end
            ST_HEADER: begin
                if (w_hs && (idx_q == 32'd3)) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                state_d = w_bad_hdr ? ST_ERROR : ST_PIXELS;
            end
            ST_PIXELS: begin
                if (w_hs && (idx_q == (pix_count_q - 32'd1))) state_d = ST_DONE;
            end
            ST_DONE, ST_ERROR: begin
                if (start) state_d = ST_HEADER;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        s_ready = 1'b0;
        busy    = 1'b0;
        case (state_q)
            ST_HEADER: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            ST_CHECK: begin
                busy    = 1'b1;
            end
            ST_PIXELS: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            default: begin
                s_ready = 1'b0;
                busy    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state: index, header capture, status flags
    // ------------------------------------------------------------------
    always_comb begin
        idx_d       = idx_q;
        width_d     = width_q;
        height_d    = height_q;
        pix_count_d = pix_count_q;
        done_d      = done_q;
        err_d       = err_q;
        hold_d      = hold_q;

        if (w_start_ok) begin
            idx_d  = 32'd0;
            done_d = 1'b0;
            err_d  = 1'b0;
            hold_d = 1'b1;
        end else begin
            case (state_q)
                ST_HEADER: begin
                    if (w_hs) begin
                        idx_d = idx_q + 32'd1;
                        case (idx_q[1:0])
                            2'd0:    width_d[15:8]  = s_data;
                            2'd1:    width_d[7:0]   = s_data;
                            2'd2:    height_d[15:8] = s_data;
                            default: height_d[7:0]  = s_data;
                        endcase
                    end
                end
                ST_CHECK: begin
                    pix_count_d = w_product;
                    idx_d       = 32'd0;
                    if (w_bad_hdr) err_d = 1'b1;
                end
                ST_PIXELS: begin
                    if (w_hs) idx_d = idx_q + 32'd1;
                end
                // Release happens one cycle after entry, so the final pixel
                // write (high during the entry cycle) lands first.
                ST_DONE: begin
                    done_d = 1'b1;
                    hold_d = 1'b0;
                end
                default: begin
                    idx_d = idx_q;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Memory write port next-state: one registered cycle after handshake
    // ------------------------------------------------------------------
    always_comb begin
        mem_we_d   = w_hs;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        if (w_hs) begin
            mem_addr_d = BASE_ADDR + ADDR_W'(w_offset);
            mem_din_d  = s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= 32'd0;
            width_q     <= 16'd0;
            height_q    <= 16'd0;
            pix_count_q <= 32'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            hold_q      <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= 8'd0;
        end else begin
            idx_q       <= idx_d;
            width_q     <= width_d;
            height_q    <= height_d;
            pix_count_q <= pix_count_d;
            done_q      <= done_d;
            err_q       <= err_d;
            hold_q      <= hold_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign cpu_hold  = hold_q;
    assign done      = done_q;
    assign err       = err_q;
    assign pix_count = pix_count_q;

endmodule
`default_nettype wire

// File: tb/tb_image_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_loader
// Description : Directed self-checking bench for image_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_din;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] pix_count;

    always #5 clk = ~clk;

    image_loader #(
        .ADDR_W     (32),
        .BASE_ADDR  (32'h100),
        .MAX_PIXELS (16384)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .pix_count (pix_count)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Memory model fed from the DUT write port, plus write-port sanity tracking.
    logic [7:0]  tmem [0:65535];
    int          wcnt    = 0;
    int          gaps    = 0;
    int          we_err  = 0;
    logic [31:0] last_addr = 32'd0;
    bit          have_last = 1'b0;
    bit          hs_prev   = 1'b0;
    bit          rst_prev  = 1'b1;
    bit          clr_req   = 1'b0;

    always @(negedge clk) begin
        if (clr_req) begin
            for (int i = 0; i < 65536; i++) tmem[i] = 8'h00;
            have_last = 1'b0;
        end
        if (!rst_prev && (mem_we !== hs_prev)) we_err++;
        if (mem_we === 1'b1) begin
            tmem[mem_addr[15:0]] = mem_din;
            wcnt++;
            if (have_last && (mem_addr != last_addr + 32'd1)) gaps++;
            last_addr = mem_addr;
            have_last = 1'b1;
        end
        hs_prev  = s_valid && s_ready;
        rst_prev = rst;
    end

    logic [7:0] stim [0:16400];
    int         w0;

    task automatic set_img(input int w, input int h, input int np, input int pbase);
        stim[0] = 8'(w >> 8);
        stim[1] = 8'(w);
        stim[2] = 8'(h >> 8);
        stim[3] = 8'(h);
        for (int i = 0; i < np; i++) stim[4+i] = 8'(pbase + i);
    endtask

    task automatic clear_mem();
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offers stim[0..n-1]; optional one-cycle start pulse while byte start_at is offered.
    task automatic stream(input int n, input bit toggle, input int start_at);
        int k   = 0;
        int cyc = 0;
        bit ph  = 1'b1;
        bit hs;
        bit sd  = 1'b0;
        while ((k < n) && (cyc < n * 3 + 20)) begin
            s_valid = toggle ? ph : 1'b1;
            s_data  = stim[k];
            start   = (k == start_at) && !sd;
            @(negedge clk);
            hs = s_valid && s_ready;
            @(posedge clk); #1;
            if (start) sd = 1'b1;
            start = 1'b0;
            if (hs) k++;
            ph = !ph;
            cyc++;
        end
        s_valid = 1'b0;
        chk("stream_bytes", k, n);
    endtask

    task automatic check_img(input string tag, input int n);
        for (int i = 0; i < n; i++) chk({tag, "_mem"}, tmem[16'h100 + i], stim[i]);
        chk({tag, "_writes"}, wcnt - w0, n);
        chk({tag, "_gaps"}, gaps, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_s_ready",  s_ready,   0);
        chk("rst_mem_we",   mem_we,    0);
        chk("rst_mem_addr", mem_addr,  0);
        chk("rst_mem_din",  mem_din,   0);
        chk("rst_cpu_hold", cpu_hold,  1);
        chk("rst_busy",     busy,      0);
        chk("rst_done",     done,      0);
        chk("rst_err",      err,       0);
        chk("rst_pix",      pix_count, 0);
        @(posedge clk); #1;

        // 1) 2x3 image, continuous valid
        clear_mem();
        set_img(2, 3, 6, 8'h10);
        w0 = wcnt;
        pulse_start();
        chk("t1_busy", busy, 1);
        stream(10, 1'b0, -1);
        @(negedge clk);
        chk("t1_last_we",   mem_we,   1);
        chk("t1_last_addr", mem_addr, 32'h109);
        chk("t1_done_early", done,    0);
        chk("t1_hold_early", cpu_hold, 1);
        @(negedge clk);
        chk("t1_done",  done,      1);
        chk("t1_hold",  cpu_hold,  0);
        chk("t1_we_off", mem_we,   0);
        chk("t1_busy_off", busy,   0);
        chk("t1_pix",   pix_count, 6);
        @(posedge clk); #1;
        check_img("t1", 10);

        // 2) Same image, valid toggling every cycle
        clear_mem();
        w0 = wcnt;
        pulse_start();
        chk("t2_done_clr", done, 0);
        chk("t2_hold_set", cpu_hold, 1);
        stream(10, 1'b1, -1);
        repeat (2) @(posedge clk); #1;
        chk("t2_done", done, 1);
        chk("t2_hold", cpu_hold, 0);
        check_img("t2", 10);

        // 3) Zero width -> ERROR
        clear_mem();
        set_img(0, 5, 0, 0);
        w0 = wcnt;
        pulse_start();
        stream(4, 1'b0, -1);
        @(negedge clk);
        chk("t3_check_busy",  busy,    1);
        chk("t3_check_ready", s_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_err",   err,      1);
        chk("t3_hold",  cpu_hold, 1);
        chk("t3_ready", s_ready,  0);
        chk("t3_busy",  busy,     0);
        chk("t3_done",  done,     0);
        @(posedge clk); #1;
        chk("t3_writes", wcnt - w0, 4);
        pulse_start();
        chk("t3_err_clr", err,     0);
        chk("t3_hdr_busy", busy,   1);
        chk("t3_hdr_ready", s_ready, 1);
        clear_mem();

        // 4a) 128x129 exceeds limit
        set_img(128, 129, 0, 0);
        stream(4, 1'b0, -1);
        repeat (3) @(posedge clk); #1;
        chk("t4a_err", err, 1);
        chk("t4a_pix", pix_count, 16512);
        chk("t4a_hold", cpu_hold, 1);

        // 4b) 128x128 is exactly the limit
        clear_mem();
        set_img(128, 128, 16384, 0);
        w0 = wcnt;
        pulse_start();
        stream(16388, 1'b0, -1);
        repeat (2) @(posedge clk); #1;
        chk("t4b_done",   done,      1);
        chk("t4b_err",    err,       0);
        chk("t4b_hold",   cpu_hold,  0);
        chk("t4b_pix",    pix_count, 16384);
        chk("t4b_writes", wcnt - w0, 16388);
        chk("t4b_last",   last_addr, 32'h4103);
        chk("t4b_m4103",  tmem[16'h4103], 8'hFF);
        chk("t4b_m4102",  tmem[16'h4102], 8'hFE);
        chk("t4b_m0104",  tmem[16'h0104], 8'h00);
        chk("t4b_gaps",   gaps, 0);

        // 5) start during PIXELS is ignored
        clear_mem();
        set_img(2, 3, 6, 8'h10);
        w0 = wcnt;
        pulse_start();
        stream(10, 1'b0, 6);
        repeat (2) @(posedge clk); #1;
        chk("t5_done", done, 1);
        chk("t5_hold", cpu_hold, 0);
        check_img("t5", 10);

        // 6) rst after 3 of 6 pixels
        clear_mem();
        w0 = wcnt;
        pulse_start();
        stream(7, 1'b0, -1);
        s_valid = 1'b1;
        s_data  = 8'hAA;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_hold",  cpu_hold, 1);
        chk("t6_done",  done,     0);
        chk("t6_we",    mem_we,   0);
        chk("t6_ready", s_ready,  0);
        chk("t6_busy",  busy,     0);
        repeat (10) @(posedge clk);
        #1;
        chk("t6_writes", wcnt - w0, 7);
        chk("t6_m0106",  tmem[16'h0106], 8'h12);
        chk("t6_m0107",  tmem[16'h0107], 8'h00);
        s_valid = 1'b0;
        @(posedge clk); #1;

        chk("we_follows_handshake", we_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
